// File: rtl/fetch_queue_if.sv
// fetch_queue packet type and handshake interface.
//
// fetch_queue_pkg  : core_instr_packet_t, the per-lane instruction packet.
// fetch_queue_if   : all Fetch-side and Next-side signals of the queue.
//   master modport : the environment (drives flush, enq_*, deq_ready).
//   slave modport  : the queue itself (drives enq_ready, deq_*, count).

package fetch_queue_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } core_instr_packet_t;
endpackage

interface fetch_queue_if #(
   parameter int ENQ_W = 2,
   parameter int DEQ_W = 2,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   import fetch_queue_pkg::*;

   logic                                flush;
   logic               [ENQ_W-1:0]      enq_valid;
   core_instr_packet_t [ENQ_W-1:0]      enq_packet;
   logic                                enq_ready;
   logic               [DEQ_W-1:0]      deq_valid;
   core_instr_packet_t [DEQ_W-1:0]      deq_packet;
   logic               [DEQ_W-1:0]      deq_ready;
   logic               [CNT_W-1:0]      count;

   modport master (
      output flush, enq_valid, enq_packet, deq_ready,
      input  enq_ready, deq_valid, deq_packet, count
   );

   modport slave (
      input  flush, enq_valid, enq_packet, deq_ready,
      output enq_ready, deq_valid, deq_packet, count
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: multi-lane in-order instruction buffer between Fetch and Next.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (pointers, count)
//   q      : fetch_queue_if.slave
//            flush            - drop contents and this cycle's enqueue
//            enq_valid/packet - ENQ_W lanes in, lane 0 oldest
//            enq_ready        - room for all ENQ_W lanes (registered state only)
//            deq_valid/packet - DEQ_W oldest entries, lane 0 oldest
//            deq_ready        - per-lane consume from Next
//            count            - occupancy 0..DEPTH
//
// Storage is a circular buffer; count (not pointer equality) tells full from
// empty. All outputs are functions of registers only.

// Per-lane slot: index = base + LANE (mod 2^PTR_W), active when LANE < limit.
module fetch_queue_lane #(
   parameter int LANE  = 0,
   parameter int PTR_W = 3,
   parameter int CNT_W = 4
) (
   input  logic [PTR_W-1:0] base,
   input  logic [CNT_W-1:0] limit,
   output logic [PTR_W-1:0] idx,
   output logic             on
);
   assign idx = base + PTR_W'(LANE);
   assign on  = CNT_W'(LANE) < limit;
endmodule

module fetch_queue #(
   parameter int ENQ_W = 2,
   parameter int DEQ_W = 2,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input logic         clk,
   input logic         rst_n,
   fetch_queue_if.slave q
);
   import fetch_queue_pkg::*;

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   core_instr_packet_t mem [DEPTH];

   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] n_enq, n_enq_acc, n_deq;
   logic             enq_ok;

   logic [ENQ_W-1:0] enq_on;
   logic [PTR_W-1:0] enq_idx [ENQ_W];
   logic [DEQ_W-1:0] deq_on;
   logic [PTR_W-1:0] deq_idx [DEQ_W];

   // Ready is all-or-nothing and looks only at the pre-dequeue count, so
   // space freed by this cycle's dequeue becomes usable next cycle.
   assign q.enq_ready = (cnt <= CNT_W'(DEPTH - ENQ_W));
   assign q.count     = cnt;
   assign enq_ok      = q.enq_ready & ~q.flush;

   // Leading-ones count: a hole in enq_valid cuts off every later lane.
   always_comb begin
      logic run;
      run   = 1'b1;
      n_enq = '0;
      for (int i = 0; i < ENQ_W; i++) begin
         run = run & q.enq_valid[i];
         if (run) n_enq = n_enq + CNT_W'(1);
      end
   end

   assign n_enq_acc = enq_ok ? n_enq : '0;

   // Same rule on the dequeue side: a ready lane behind a stalled one
   // consumes nothing.
   always_comb begin
      logic run;
      run   = 1'b1;
      n_deq = '0;
      for (int i = 0; i < DEQ_W; i++) begin
         run = run & deq_on[i] & q.deq_ready[i];
         if (run) n_deq = n_deq + CNT_W'(1);
      end
   end

   for (genvar i = 0; i < ENQ_W; i++) begin : g_enq
      fetch_queue_lane #(.LANE(i), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_lane (
         .base  (wr_ptr),
         .limit (n_enq_acc),
         .idx   (enq_idx[i]),
         .on    (enq_on[i])
      );
   end

   for (genvar i = 0; i < DEQ_W; i++) begin : g_deq
      fetch_queue_lane #(.LANE(i), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_lane (
         .base  (rd_ptr),
         .limit (cnt),
         .idx   (deq_idx[i]),
         .on    (deq_on[i])
      );
   end

   assign q.deq_valid = deq_on;

   // Packet on an invalid lane is whatever the slot holds (don't-care).
   always_comb begin
      for (int i = 0; i < DEQ_W; i++) q.deq_packet[i] = mem[deq_idx[i]];
   end

   // Pointer widths equal log2(DEPTH), so truncating adds wrap mod DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (q.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         rd_ptr <= rd_ptr + PTR_W'(n_deq);
         wr_ptr <= wr_ptr + PTR_W'(n_enq_acc);
         cnt    <= cnt + n_enq_acc - n_deq;
      end
   end

   // Storage has no reset; validity lives entirely in count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < ENQ_W; i++) begin
         if (enq_on[i]) mem[enq_idx[i]] <= q.enq_packet[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) assert (cnt <= CNT_W'(DEPTH))
         else $error("fetch_queue: occupancy above DEPTH");
   end

endmodule
